// File: rtl/hazard_unit_mc_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the multi-cycle pipeline hazard unit.
//   FWD_*      : encodings of the E-stage operand forwarding selects
//   mdState_t  : states of the multiply/divide interlock FSM
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W   = 2'b01;  // W-stage result
    localparam logic [1:0] FWD_M   = 2'b10;  // M-stage ALU result
    localparam logic [1:0] FWD_LUI = 2'b11;  // M-stage LUI immediate

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// ----------------------------------------------------------------------------
// hazard_unit_mc_if
// Bundles the datapath <-> hazard unit signals.
//   Datapath -> hazard : rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, rdM,
//                        rdW, loadE, regWriteM, regWriteW, luiM, pcSrcE,
//                        mdStartE
//   Hazard -> datapath : forwardAE, forwardBE, stallF, stallD, stallE,
//                        flushD, flushE, flushM, mdBusy
// Modports:
//   master : datapath side (drives pipeline info, receives controls)
//   slave  : hazard unit side
// ----------------------------------------------------------------------------
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5
);

    logic [REG_AW-1:0] rs1D;
    logic [REG_AW-1:0] rs2D;
    logic              useRs1D;
    logic              useRs2D;
    logic [REG_AW-1:0] rs1E;
    logic [REG_AW-1:0] rs2E;
    logic [REG_AW-1:0] rdE;
    logic [REG_AW-1:0] rdM;
    logic [REG_AW-1:0] rdW;
    logic              loadE;
    logic              regWriteM;
    logic              regWriteW;
    logic              luiM;
    logic [1:0]        pcSrcE;
    logic              mdStartE;

    logic [1:0]        forwardAE;
    logic [1:0]        forwardBE;
    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              flushD;
    logic              flushE;
    logic              flushM;
    logic              mdBusy;

    modport master (
        output rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, rdM, rdW,
               loadE, regWriteM, regWriteW, luiM, pcSrcE, mdStartE,
        input  forwardAE, forwardBE, stallF, stallD, stallE,
               flushD, flushE, flushM, mdBusy
    );

    modport slave (
        input  rs1D, rs2D, useRs1D, useRs2D, rs1E, rs2E, rdE, rdM, rdW,
               loadE, regWriteM, regWriteW, luiM, pcSrcE, mdStartE,
        output forwardAE, forwardBE, stallF, stallD, stallE,
               flushD, flushE, flushM, mdBusy
    );

endinterface

// File: rtl/hazard_unit_mc_fwd_sel.sv
// ----------------------------------------------------------------------------
// hazard_fwd_sel
// Combinational forwarding select for one E-stage source operand.
// Ports:
//   rsE        in  source register index in E
//   rdM, rdW   in  destination indices in M and W
//   regWriteM  in  M instruction writes a register
//   regWriteW  in  W instruction writes a register
//   luiM       in  M instruction is LUI (result is the immediate)
//   fwdSel     out forwarding select (hazard_pkg::FWD_*)
// ----------------------------------------------------------------------------
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteM,
    input  logic              regWriteW,
    input  logic              luiM,
    output logic [1:0]        fwdSel
);

    // x0 never forwards; the younger M result shadows W.
    always_comb begin
        fwdSel = FWD_RF;
        if (rsE != '0) begin
            if (regWriteM && (rsE == rdM)) begin
                fwdSel = luiM ? FWD_LUI : FWD_M;
            end else if (regWriteW && (rsE == rdW)) begin
                fwdSel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// ----------------------------------------------------------------------------
// hazard_unit_mc
// Hazard unit for a 5-stage RISC-V pipeline with a variable-latency
// multiply/divide unit that holds its instruction in E for MD_LAT cycles.
// Produces forwarding selects, load-use stalls, redirect flushes and the
// MD interlock.
// Parameters:
//   REG_AW : register index width
//   MD_LAT : cycles an MD instruction occupies E (>= 1)
//   CNT_W  : performance counter width
// Ports:
//   clk    in  pipeline clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   hz     slave side of hazard_unit_mc_if
// Optional (macro HAZARD_PERF_CNT_EN defined):
//   stallCycles  out cycles with stallF high (saturating)
//   flushEvents  out cycles with flushD or flushE high (saturating)
//   mdCycles     out cycles with mdBusy high (saturating)
// ----------------------------------------------------------------------------
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_unit_mc_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stallCycles,
    output logic [CNT_W-1:0]    flushEvents,
    output logic [CNT_W-1:0]    mdCycles
`endif
);

    localparam int MD_CW    = $clog2(MD_LAT) + 1;
    localparam bit MD_MULTI = (MD_LAT > 1);

    // Reject nonsensical configurations at elaboration.
    if (MD_LAT < 1 || CNT_W < 1) begin : gBadParam
        $error("hazard_unit_mc: MD_LAT and CNT_W must be >= 1");
    end

    mdState_t          state;
    mdState_t          stateNext;
    logic [MD_CW-1:0]  cnt;
    logic [MD_CW-1:0]  cntNext;

    logic lwStall;
    logic redirect;
    logic mdStartOk;
    logic mdBusyInt;
    logic lwGated;
    logic redirGated;

    hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdA (
        .rsE       (hz.rs1E),
        .rdM       (hz.rdM),
        .rdW       (hz.rdW),
        .regWriteM (hz.regWriteM),
        .regWriteW (hz.regWriteW),
        .luiM      (hz.luiM),
        .fwdSel    (hz.forwardAE)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdB (
        .rsE       (hz.rs2E),
        .rdM       (hz.rdM),
        .rdW       (hz.rdW),
        .regWriteM (hz.regWriteM),
        .regWriteW (hz.regWriteW),
        .luiM      (hz.luiM),
        .fwdSel    (hz.forwardBE)
    );

    // Hazard detection; a redirect squashes an MD op before it starts.
    always_comb begin
        lwStall   = hz.loadE && (hz.rdE != '0) &&
                    ((hz.useRs1D && (hz.rs1D == hz.rdE)) ||
                     (hz.useRs2D && (hz.rs2D == hz.rdE)));
        redirect  = (hz.pcSrcE != 2'b00);
        mdStartOk = hz.mdStartE && !redirect && MD_MULTI;
    end

    // MD interlock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // The first E cycle is served from IDLE, so BUSY only covers the
    // remaining MD_LAT-1 cycles; cnt counts those down to 1.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            MD_IDLE: begin
                if (mdStartOk) begin
                    stateNext = MD_BUSY;
                    cntNext   = MD_CW'(MD_LAT - 1);
                end
            end
            MD_BUSY: begin
                cntNext = cnt - MD_CW'(1);
                if (cnt == MD_CW'(1)) begin
                    stateNext = MD_IDLE;
                end
            end
            default: begin
                stateNext = MD_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Pipeline controls; everything is held low while reset is asserted,
    // and the MD interlock overrides load-use and redirect flushes.
    always_comb begin
        mdBusyInt  = rst_n && ((state == MD_BUSY) ||
                               ((state == MD_IDLE) && mdStartOk));
        lwGated    = rst_n && lwStall;
        redirGated = rst_n && redirect;

        hz.mdBusy = mdBusyInt;
        hz.stallF = lwGated || mdBusyInt;
        hz.stallD = lwGated || mdBusyInt;
        hz.stallE = mdBusyInt;
        hz.flushM = mdBusyInt;
        hz.flushD = redirGated && !mdBusyInt;
        hz.flushE = (lwGated || redirGated) && !mdBusyInt;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles <= '0;
            flushEvents <= '0;
            mdCycles    <= '0;
        end else begin
            if (hz.stallF && (stallCycles != '1)) begin
                stallCycles <= stallCycles + CNT_W'(1);
            end
            if ((hz.flushD || hz.flushE) && (flushEvents != '1)) begin
                flushEvents <= flushEvents + CNT_W'(1);
            end
            if (mdBusyInt && (mdCycles != '1)) begin
                mdCycles <= mdCycles + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit_mc
// Self-checking bench for hazard_unit_mc. Directed scenarios followed by
// random traffic; expectations come from a behavioural model and are
// checked by a monitor through a scoreboard queue.
// Counter outputs are checked when HAZARD_PERF_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_hazard_unit_mc;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rs1D;
        logic [REG_AW-1:0] rs2D;
        logic              useRs1D;
        logic              useRs2D;
        logic [REG_AW-1:0] rs1E;
        logic [REG_AW-1:0] rs2E;
        logic [REG_AW-1:0] rdE;
        logic [REG_AW-1:0] rdM;
        logic [REG_AW-1:0] rdW;
        logic              loadE;
        logic              regWriteM;
        logic              regWriteW;
        logic              luiM;
        logic [1:0]        pcSrcE;
        logic              mdStartE;
        logic              rstn;
    } stim_t;

    typedef struct packed {
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic [6:0]  ctl;   // stallF stallD stallE flushD flushE flushM mdBusy
        logic [31:0] stallCnt;
        logic [31:0] flushCnt;
        logic [31:0] mdCnt;
    } exp_t;

    logic clk;
    logic rst_n;

    hazard_unit_mc_if #(.REG_AW(REG_AW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushEvents;
    logic [CNT_W-1:0] mdCycles;
`endif

    hazard_unit_mc #(
        .REG_AW (REG_AW),
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCycles (stallCycles),
        .flushEvents (flushEvents),
        .mdCycles    (mdCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sbq[$];
    int   assertCount = 0;
    int   failCount   = 0;

    // Model state: MD cycles still owed after the current one, and counters.
    int     mdOwed   = 0;
    longint stallMod = 0;
    longint flushMod = 0;
    longint mdMod    = 0;

    function automatic logic [1:0] refFwd(input stim_t s, input logic [REG_AW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (s.regWriteM && s.rdM == rs) return s.luiM ? 2'b11 : 2'b10;
        if (s.regWriteW && s.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    // Drive one cycle of inputs, push the predicted response, advance model.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   lw, redir, startOk, busy, sF, fD, fE;
        @(posedge clk);
        #1;
        rst_n        = s.rstn;
        hz.rs1D      = s.rs1D;
        hz.rs2D      = s.rs2D;
        hz.useRs1D   = s.useRs1D;
        hz.useRs2D   = s.useRs2D;
        hz.rs1E      = s.rs1E;
        hz.rs2E      = s.rs2E;
        hz.rdE       = s.rdE;
        hz.rdM       = s.rdM;
        hz.rdW       = s.rdW;
        hz.loadE     = s.loadE;
        hz.regWriteM = s.regWriteM;
        hz.regWriteW = s.regWriteW;
        hz.luiM      = s.luiM;
        hz.pcSrcE    = s.pcSrcE;
        hz.mdStartE  = s.mdStartE;

        lw      = s.loadE && s.rdE != 0 &&
                  ((s.useRs1D && s.rs1D == s.rdE) || (s.useRs2D && s.rs2D == s.rdE));
        redir   = s.pcSrcE != 0;
        startOk = s.mdStartE && !redir && (MD_LAT > 1);
        busy    = (mdOwed > 0) || startOk;

        if (!s.rstn) begin
            lw = 0; redir = 0; busy = 0;
            mdOwed = 0; stallMod = 0; flushMod = 0; mdMod = 0;
        end

        sF = lw || busy;
        fD = redir && !busy;
        fE = (lw || redir) && !busy;

        e.fwdA     = refFwd(s, s.rs1E);
        e.fwdB     = refFwd(s, s.rs2E);
        e.ctl      = {sF, sF, busy, fD, fE, busy, busy};
        e.stallCnt = 32'(stallMod);
        e.flushCnt = 32'(flushMod);
        e.mdCnt    = 32'(mdMod);
        sbq.push_back(e);

        if (s.rstn) begin
            if (mdOwed > 0) mdOwed = mdOwed - 1;
            else if (startOk) mdOwed = MD_LAT - 1;
            if (sF) stallMod++;
            if (fD || fE) flushMod++;
            if (busy) mdMod++;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] ctlAct;
        ctlAct = {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM, hz.mdBusy};
        assertCount++;
        if (hz.forwardAE !== e.fwdA) begin
            failCount++;
            $display("[TB] FAIL fwdA: got %b expected %b at %0t", hz.forwardAE, e.fwdA, $time);
        end
        assertCount++;
        if (hz.forwardBE !== e.fwdB) begin
            failCount++;
            $display("[TB] FAIL fwdB: got %b expected %b at %0t", hz.forwardBE, e.fwdB, $time);
        end
        assertCount++;
        if (ctlAct !== e.ctl) begin
            failCount++;
            $display("[TB] FAIL ctl(sF sD sE fD fE fM busy): got %b expected %b at %0t",
                     ctlAct, e.ctl, $time);
        end
`ifdef HAZARD_PERF_CNT_EN
        assertCount++;
        if (stallCycles !== e.stallCnt || flushEvents !== e.flushCnt || mdCycles !== e.mdCnt) begin
            failCount++;
            $display("[TB] FAIL perfCnt: got %0d/%0d/%0d expected %0d/%0d/%0d at %0t",
                     stallCycles, flushEvents, mdCycles, e.stallCnt, e.flushCnt, e.mdCnt, $time);
        end
`endif
    endtask

    // Monitor: outputs are valid every cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            checkOutput(sbq.pop_front());
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b1;
        s = idleStim();
        hz.rs1D = '0; hz.rs2D = '0; hz.useRs1D = 0; hz.useRs2D = 0;
        hz.rs1E = '0; hz.rs2E = '0; hz.rdE = '0; hz.rdM = '0; hz.rdW = '0;
        hz.loadE = 0; hz.regWriteM = 0; hz.regWriteW = 0; hz.luiM = 0;
        hz.pcSrcE = '0; hz.mdStartE = 0;
        #2 rst_n = 1'b0;

        // Reset state
        s.rstn = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        // Forwarding priority, LUI path, x0, W-only match
        s = idleStim();
        s.rs1E = 5; s.rdM = 5; s.regWriteM = 1; s.rdW = 5; s.regWriteW = 1;
        applyStimulus(s);
        s.luiM = 1;
        applyStimulus(s);
        s.rs1E = 0;
        applyStimulus(s);
        s = idleStim();
        s.rs2E = 6; s.rdW = 6; s.regWriteW = 1; s.rdM = 6;
        applyStimulus(s);

        // Load-use stall and its non-triggering variants
        s = idleStim();
        s.loadE = 1; s.rdE = 7; s.rs2D = 7; s.useRs2D = 1;
        applyStimulus(s);
        s.useRs2D = 0;
        applyStimulus(s);
        s.useRs2D = 1; s.rdE = 0; s.rs2D = 0;
        applyStimulus(s);

        // MD interlock, with a re-start while busy being ignored
        s = idleStim();
        s.mdStartE = 1;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);
        s.mdStartE = 1;
        applyStimulus(s);
        s = idleStim();
        for (int i = 0; i < 3; i++) applyStimulus(s);

        // MD start coinciding with a redirect
        s = idleStim();
        s.mdStartE = 1; s.pcSrcE = 2'b01;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        // Reset during BUSY
        s = idleStim();
        s.mdStartE = 1;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);
        s.rstn = 1'b0;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);
        applyStimulus(s);

        // MD op followed by one load-use stall (counter scenario)
        s = idleStim();
        s.mdStartE = 1;
        applyStimulus(s);
        s = idleStim();
        for (int i = 0; i < 4; i++) applyStimulus(s);
        s.loadE = 1; s.rdE = 3; s.rs1D = 3; s.useRs1D = 1;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        // Random traffic over a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            s.rs1D      = REG_AW'($urandom_range(0, 3));
            s.rs2D      = REG_AW'($urandom_range(0, 3));
            s.useRs1D   = 1'($urandom);
            s.useRs2D   = 1'($urandom);
            s.rs1E      = REG_AW'($urandom_range(0, 3));
            s.rs2E      = REG_AW'($urandom_range(0, 3));
            s.rdE       = REG_AW'($urandom_range(0, 3));
            s.rdM       = REG_AW'($urandom_range(0, 3));
            s.rdW       = REG_AW'($urandom_range(0, 3));
            s.loadE     = ($urandom_range(0, 3) == 0);
            s.regWriteM = 1'($urandom);
            s.regWriteW = 1'($urandom);
            s.luiM      = 1'($urandom);
            s.pcSrcE    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s.mdStartE  = ($urandom_range(0, 5) == 0);
            s.rstn      = ($urandom_range(0, 79) != 0);
            applyStimulus(s);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() > 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
